// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Fixed latency of WIDTH+2 cycles from start to the done pulse, abortable by flush.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mop;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;

  // Multiply: acc_lo holds the multiplier, product bits shift in from the top.
  // Divide: acc_lo holds the dividend, quotient bits shift in from the bottom.
  always_comb begin
    mul_sum   = acc_lo[0] ? (acc_hi + {1'b0, mop}) : acc_hi;
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mop};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial;
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -acc_lo : acc_lo;
    rem      = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mop      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= CNT_W'(WIDTH - 1);
            acc_hi   <= '0;
            acc_lo   <= op[1] ? mag_a : mag_b;
            mop      <= op[1] ? mag_b : mag_a;
            a_raw    <= a;
            is_div   <= op[1];
            neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= op[0] & op[1] & a[WIDTH-1];
            div_zero <= op[1] & (b == '0);
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt == '0) state <= FIX;
            else cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit instance for the main scenarios and
// an 8-bit instance for the narrow-width latency and result checks.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        flush, hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        flush8, hi_we8, lo_we8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference result {hi, lo} for a 32-bit operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy;
    int ix, iy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ix = $signed(x);
    iy = $signed(y);
    case (o)
      2'd0: r = {32'd0, x} * {32'd0, y};
      2'd1: r = 64'(sx * sy);
      2'd2: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else r = {32'(ix % iy), 32'(ix / iy)};
      end
    endcase
    return r;
  endfunction

  // Drive start for the current cycle (cycle 0); returns just after the next edge (cycle 1).
  task automatic issue_now(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit track);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (track) exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit track);
    @(posedge clk); #1;
    issue_now(o, x, y, track);
  endtask

  // Returns the cycle index at which done is seen (-1 on timeout), sampled mid-cycle.
  task automatic wait_done(input int first, output int cyc, output int busy_n);
    cyc    = first;
    busy_n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_n++;
      if (cyc >= first + 100) begin
        cyc = -1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00", {busy, done});
    end
    n_cmp++;
    if ({hi, lo} !== 64'd0) begin
      n_bad++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_multu_max;
    int cyc, bn;
    logic [63:0] e;
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done(1, cyc, bn);
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL multu_latency: got %0d expected 34", cyc); end
    n_cmp++;
    if (bn !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d expected 33", bn); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
    pop_exp(e);
    n_cmp++;
    if ({hi, lo} !== e) begin n_bad++; $display("FAIL multu_sb: got %h expected %h", {hi, lo}, e); end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      n_bad++; $display("FAIL multu_const: got %h expected fffffffe00000001", {hi, lo});
    end
    $display("multu max: cycle=%0d busy_cycles=%0d hi=%h lo=%h", cyc, bn, hi, lo);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [6] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [31:0] t_a  [6] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9, 32'd100};
    logic [31:0] t_b  [6] = '{32'd5, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd7};
    logic [63:0] t_r  [6] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD, 64'h00000007_FFFFFFFF,
                              64'h00000000_80000000, 64'hFFFFFFF9_FFFFFFFF, 64'h00000002_0000000E};
    int cyc, bn;
    logic [63:0] e;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b1);
      wait_done(1, cyc, bn);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 34) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected 34", i, cyc); end
      n_cmp++;
      if ({hi, lo} !== t_r[i]) begin
        n_bad++; $display("FAIL directed_const[%0d]: got %h expected %h", i, {hi, lo}, t_r[i]);
      end
      n_cmp++;
      if ({hi, lo} !== e) begin n_bad++; $display("FAIL directed_sb[%0d]: got %h expected %h", i, {hi, lo}, e); end
      $display("directed op=%0d a=%h b=%h -> hi=%h lo=%h cycle=%0d", t_op[i], t_a[i], t_b[i], hi, lo, cyc);
    end
  endtask

  task automatic test_random;
    int cyc, bn;
    logic [63:0] e;
    logic [1:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(1, 20));
        1: y = -32'($urandom_range(1, 20));
        2: y = 32'd0;
        default: y = $urandom;
      endcase
      issue(o, x, y, 1'b1);
      wait_done(1, cyc, bn);
      pop_exp(e);
      n_cmp++;
      if ({hi, lo} !== e) begin n_bad++; $display("FAIL random_sb[%0d]: got %h expected %h", i, {hi, lo}, e); end
      $display("random op=%0d a=%h b=%h -> hi=%h lo=%h cycle=%0d", o, x, y, hi, lo, cyc);
    end
  endtask

  task automatic test_flush;
    int cyc, bn;
    logic [63:0] e;
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    issue(2'd0, 32'd2, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL flush_flags: got %b expected 00", {busy, done}); end
    n_cmp++;
    if (hi !== 32'h1234) begin n_bad++; $display("FAIL flush_hi: got %h expected 00001234", hi); end
    $display("flush: busy=%b done=%b hi=%h", busy, done, hi);
    issue_now(2'd0, 32'd2, 32'd3, 1'b1);
    wait_done(1, cyc, bn);
    pop_exp(e);
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL restart_latency: got %0d expected 34", cyc); end
    n_cmp++;
    if ({hi, lo} !== 64'h00000000_00000006) begin
      n_bad++; $display("FAIL restart_const: got %h expected 6", {hi, lo});
    end
    n_cmp++;
    if ({hi, lo} !== e) begin n_bad++; $display("FAIL restart_sb: got %h expected %h", {hi, lo}, e); end
    $display("restart after flush: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
  endtask

  task automatic test_busy_ignore;
    int cyc, bn;
    logic [63:0] e;
    issue(2'd0, 32'h1111, 32'h10, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'd2; a = 32'd99; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(6, cyc, bn);
    pop_exp(e);
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 34", cyc); end
    n_cmp++;
    if ({hi, lo} !== e) begin n_bad++; $display("FAIL ignore_sb: got %h expected %h", {hi, lo}, e); end
    $display("busy ignore: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
    // second operation launched in the done cycle itself
    issue_now(2'd1, 32'hFFFF0000, 32'h00012345, 1'b1);
    wait_done(1, cyc, bn);
    pop_exp(e);
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 34", cyc); end
    n_cmp++;
    if ({hi, lo} !== e) begin n_bad++; $display("FAIL b2b_sb: got %h expected %h", {hi, lo}, e); end
    $display("back to back: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
  endtask

  task automatic test_mt_with_start;
    int cyc, bn;
    logic [63:0] e;
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'h5555;
    start = 1'b1; op = 2'd0; a = 32'd4; b = 32'd5;
    exp_q.push_back(model(2'd0, 32'd4, 32'd5));
    @(posedge clk); #1;
    lo_we = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, lo} !== {1'b1, 32'h5555}) begin
      n_bad++; $display("FAIL mt_start_write: got %h expected 100005555", {busy, lo});
    end
    wait_done(2, cyc, bn);
    pop_exp(e);
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL mt_start_latency: got %0d expected 34", cyc); end
    n_cmp++;
    if ({hi, lo} !== e) begin n_bad++; $display("FAIL mt_start_sb: got %h expected %h", {hi, lo}, e); end
    $display("mt with start: hi=%h lo=%h cycle=%0d", hi, lo, cyc);
  endtask

  task automatic test_async_reset;
    int dn;
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'd0, 32'd3, 32'd4, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL async_reset_flags: got %b expected 00", {busy, done}); end
    n_cmp++;
    if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL async_reset_hilo: got %h expected 0", {hi, lo}); end
    $display("async reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(posedge clk); #1;
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_bad++; $display("FAIL reset_abort: got %0d active cycles expected 0", dn); end
  endtask

  task automatic test_width8;
    logic [1:0] t_op [3] = '{2'd0, 2'd3, 2'd3};
    logic [7:0] t_a  [3] = '{8'hFF, 8'h80, 8'hF9};
    logic [7:0] t_b  [3] = '{8'hFF, 8'hFF, 8'h02};
    logic [15:0] t_r [3] = '{16'hFE01, 16'h0080, 16'hFFFD};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start8 = 1'b1; op8 = t_op[i]; a8 = t_a[i]; b8 = t_b[i];
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 1;
      forever begin
        @(negedge clk);
        if (done8) break;
        if (cyc >= 50) begin cyc = -1; break; end
        @(posedge clk); #1;
        cyc++;
      end
      n_cmp++;
      if (cyc !== 10) begin n_bad++; $display("FAIL w8_latency[%0d]: got %0d expected 10", i, cyc); end
      n_cmp++;
      if ({hi8, lo8} !== t_r[i]) begin
        n_bad++; $display("FAIL w8_result[%0d]: got %h expected %h", i, {hi8, lo8}, t_r[i]);
      end
      $display("width8 op=%0d a=%h b=%h -> hi=%h lo=%h cycle=%0d", t_op[i], t_a[i], t_b[i], hi8, lo8, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; op = 2'd0; a = '0; b = '0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0; flush8 = 1'b0;
    hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_multu_max;
    test_directed;
    test_random;
    test_flush;
    test_busy_ignore;
    test_mt_with_start;
    test_async_reset;
    test_width8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage of the pipelined core and implements MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Supersedes single-cycle combinational arithmetic with a radix-2 shift-add / restoring-divide engine.
- Signals `busy` so the hazard logic can stall the front end.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Legal values: 8..64.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  launch operation; sampled only when not busy
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- flush  input  1  synchronous abort of the in-flight operation
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset asserted mid-operation aborts it immediately; no done pulse.
- FSM states:
  - IDLE: if start, latch operands, go to RUN with counter=WIDTH-1.
  - RUN: one iteration per cycle; at counter=0, go to FIX; otherwise decrement the counter.
  - FIX: apply sign correction, write HI/LO, assert done on the next cycle, go to IDLE.
- busy=1 in RUN and FIX, 0 otherwise; it is a registered output.
- Latency:
  - start high in cycle 0 (IDLE).
  - RUN occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - hi/lo hold the new values and done=1 in cycle WIDTH+2, with busy=0 in that same cycle.
  - Fixed latency for all ops and operands; no early termination.
- start while busy is ignored. start in the cycle done is high is accepted (state is IDLE).
- Signed ops (MULT, DIV): operands are converted to magnitudes at start; the sign is corrected in FIX.
- Multiply: {hi,lo} = full 2*WIDTH-bit product (signed or unsigned).
- Divide: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- Divide by zero (b=0, DIVU or DIV): hi=a, lo=all ones. Normal latency and normal done pulse.
- Signed overflow (DIV of the most negative value by -1): lo=most negative value, hi=0.
- flush: when busy, return to IDLE on the next edge. hi/lo are unchanged, no done, busy=0 the next cycle. flush while IDLE has no effect; flush overrides a simultaneous start.
- MTHI/MTLO: hi_we/lo_we write wdata on the edge only when busy=0. They are ignored while busy; hazard logic must stall these instructions.
- An MT write and an accepted start in the same IDLE cycle: the write takes effect, and the operation later overwrites both registers at completion.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start in cycle 0 -> busy cycles 1..33; done=1 in cycle 34 only; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=0 -> hi=0x00000007, lo=0xFFFFFFFF at cycle 34. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Pre-load hi=0x1234 via MTHI, then start MULTU 2*3 and assert flush in cycle 10 -> busy=0 in cycle 11, no done, hi=0x1234. Assert start again in cycle 11 -> hi=0, lo=6 in cycle 45.
- During busy: start with new operands and hi_we=1 (wdata=0xAAAA) -> both ignored; first result is intact. Back-to-back start in the done cycle -> second done exactly WIDTH+2 cycles later.
- Assert reset asynchronously mid-RUN (between clock edges) -> busy/done/hi/lo go to 0 without waiting for an edge. Also run WIDTH=8 on a bench: 0xFF*0xFF -> hi=0xFE, lo=0x01, done at cycle 10.
